// File: rtl/dma_job_scheduler.sv
// Shares one DMAC between the weight and image loaders: round-robin grant,
// Start/Done handshake tracking, DMAC reset pulse between jobs, watchdog.
module dma_job_scheduler #(
    parameter int ADDR_W     = 22,
    parameter int SIZE_W     = 32,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 600000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              W_Req,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [SIZE_W-1:0] W_DSize,
    input  logic [SIZE_W-1:0] W_SSize,
    output logic              W_Grant,
    output logic              W_Done,
    input  logic              I_Req,
    input  logic [ADDR_W-1:0] I_Addr,
    input  logic [SIZE_W-1:0] I_DSize,
    input  logic [SIZE_W-1:0] I_SSize,
    output logic              I_Grant,
    output logic              I_Done,
    output logic              DMAC_RST,
    output logic [1:0]        DMAC_Start,
    output logic [ADDR_W-1:0] DMAC_DRAM_START_A,
    output logic [SIZE_W-1:0] DMAC_DRAM_SIZE,
    output logic [SIZE_W-1:0] DMAC_SRAM_SIZE,
    input  logic              DMA_Start,
    input  logic              DMA_Done,
    output logic              Busy,
    output logic              Owner,
    output logic              Err
);
    localparam int                RC_W    = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0]   RC_LOAD = RC_W'(RST_CYCLES);
    localparam bit                TO_EN   = (TIMEOUT != 0);
    localparam logic [31:0]       TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_DRST, S_IDLE, S_ISSUE, S_RUN, S_DONE} state_t;

    state_t            state;
    logic [RC_W-1:0]   rst_cnt;
    logic [31:0]       wd_cnt;
    logic              last;       // 1 = image owned the previous grant
    logic              zero_job;

    logic              pick_img;
    logic [ADDR_W-1:0] sel_addr;
    logic [SIZE_W-1:0] sel_dsize;
    logic [SIZE_W-1:0] sel_ssize;
    logic              sel_zero;
    logic              timeout_hit;

    always_comb begin
        pick_img    = I_Req && (!W_Req || !last);
        sel_addr    = pick_img ? I_Addr  : W_Addr;
        sel_dsize   = pick_img ? I_DSize : W_DSize;
        sel_ssize   = pick_img ? I_SSize : W_SSize;
        sel_zero    = (sel_dsize == '0) || (sel_ssize == '0);
        // the counter reaches TIMEOUT on the edge that fires
        timeout_hit = TO_EN && (wd_cnt == TO_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state             <= S_DRST;
            rst_cnt           <= RC_LOAD;
            wd_cnt            <= '0;
            last              <= 1'b1;
            zero_job          <= 1'b0;
            DMAC_RST          <= 1'b1;
            DMAC_Start        <= 2'b00;
            DMAC_DRAM_START_A <= '0;
            DMAC_DRAM_SIZE    <= '0;
            DMAC_SRAM_SIZE    <= '0;
            W_Grant           <= 1'b0;
            I_Grant           <= 1'b0;
            W_Done            <= 1'b0;
            I_Done            <= 1'b0;
            Busy              <= 1'b0;
            Owner             <= 1'b0;
            Err               <= 1'b0;
        end else begin
            W_Grant <= 1'b0;
            I_Grant <= 1'b0;
            W_Done  <= 1'b0;
            I_Done  <= 1'b0;
            case (state)
                S_DRST: begin
                    if (rst_cnt == '0) begin
                        DMAC_RST <= 1'b0;
                        Busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        DMAC_RST <= 1'b1;
                        Busy     <= 1'b1;
                        rst_cnt  <= rst_cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (W_Req || I_Req) begin
                        W_Grant           <= !pick_img;
                        I_Grant           <= pick_img;
                        Owner             <= pick_img;
                        last              <= pick_img;
                        DMAC_DRAM_START_A <= sel_addr;
                        DMAC_DRAM_SIZE    <= sel_dsize;
                        DMAC_SRAM_SIZE    <= sel_ssize;
                        Busy              <= 1'b1;
                        wd_cnt            <= '0;
                        zero_job          <= sel_zero;
                        // empty descriptors complete without touching the DMAC
                        if (sel_zero) begin
                            DMAC_Start <= 2'b00;
                            state      <= S_DONE;
                        end else begin
                            DMAC_Start <= pick_img ? 2'b01 : 2'b11;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (DMA_Done) begin
                        DMAC_Start <= 2'b00;
                        state      <= S_DONE;
                    end else if (timeout_hit) begin
                        DMAC_Start <= 2'b00;
                        Err        <= 1'b1;
                        state      <= S_DONE;
                    end else if (DMA_Start) begin
                        DMAC_Start <= 2'b00;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (DMA_Done) begin
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        Err   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    W_Done <= !Owner;
                    I_Done <= Owner;
                    if (zero_job) begin
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        rst_cnt <= RC_LOAD;
                        state   <= S_DRST;
                    end
                end
                default: state <= S_DRST;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_job_scheduler.sv
// Directed plus randomized jobs checked cycle by cycle against an event-time model.
module tb_dma_job_scheduler;
    localparam int AW = 22;
    localparam int SW = 32;
    localparam int RC = 2;
    localparam int TO = 1200;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          W_Req = 1'b0, I_Req = 1'b0;
    logic [AW-1:0] W_Addr = '0, I_Addr = '0;
    logic [SW-1:0] W_DSize = '0, W_SSize = '0, I_DSize = '0, I_SSize = '0;
    logic          W_Grant, W_Done, I_Grant, I_Done;
    logic          DMAC_RST;
    logic [1:0]    DMAC_Start;
    logic [AW-1:0] DMAC_DRAM_START_A;
    logic [SW-1:0] DMAC_DRAM_SIZE, DMAC_SRAM_SIZE;
    logic          DMA_Start = 1'b0, DMA_Done = 1'b0;
    logic          Busy, Owner, Err;

    always #5 CLK = ~CLK;

    dma_job_scheduler #(.ADDR_W(AW), .SIZE_W(SW), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .W_Req(W_Req), .W_Addr(W_Addr), .W_DSize(W_DSize), .W_SSize(W_SSize),
        .W_Grant(W_Grant), .W_Done(W_Done),
        .I_Req(I_Req), .I_Addr(I_Addr), .I_DSize(I_DSize), .I_SSize(I_SSize),
        .I_Grant(I_Grant), .I_Done(I_Done),
        .DMAC_RST(DMAC_RST), .DMAC_Start(DMAC_Start),
        .DMAC_DRAM_START_A(DMAC_DRAM_START_A),
        .DMAC_DRAM_SIZE(DMAC_DRAM_SIZE), .DMAC_SRAM_SIZE(DMAC_SRAM_SIZE),
        .DMA_Start(DMA_Start), .DMA_Done(DMA_Done),
        .Busy(Busy), .Owner(Owner), .Err(Err)
    );

    int checks = 0;
    int errors = 0;
    int t = 0;          // index of the most recent clock edge
    int m_idle = 0;     // edge at which the scheduler is back in IDLE
    bit m_last = 1'b1;  // 1 = image was granted last
    bit m_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        t++;
    endtask

    task automatic chk_reset_vals();
        chk("rst_dmac_rst", DMAC_RST, 1);
        chk("rst_start", DMAC_Start, 0);
        chk("rst_addr", DMAC_DRAM_START_A, 0);
        chk("rst_dsize", DMAC_DRAM_SIZE, 0);
        chk("rst_ssize", DMAC_SRAM_SIZE, 0);
        chk("rst_grants", {W_Grant, I_Grant}, 0);
        chk("rst_dones", {W_Done, I_Done}, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_owner", Owner, 0);
        chk("rst_err", Err, 0);
    endtask

    task automatic do_reset();
        RST = 1'b1; W_Req = 1'b0; I_Req = 1'b0; DMA_Start = 1'b0; DMA_Done = 1'b0;
        tick(); chk_reset_vals();
        tick(); chk_reset_vals();
        RST = 1'b0;
        for (int i = 1; i <= RC; i++) begin
            tick();
            chk("drst_dmac_rst", DMAC_RST, 1);
            chk("drst_busy", Busy, 1);
        end
        tick();
        chk("idle_dmac_rst", DMAC_RST, 0);
        chk("idle_busy", Busy, 0);
        m_idle = t; m_last = 1'b1; m_err = 1'b0;
    endtask

    // One job from the current Req/descriptor inputs. sdly/ddly: edge offsets after the
    // grant at which DMA_Start/DMA_Done are presented (0 = never).
    task automatic job(input int sdly, input int ddly);
        bit win, zero, tout;
        logic [AW-1:0] ea;
        logic [SW-1:0] eds, ess;
        logic [1:0] code, dn;
        int g, d, lo, idle_at;
        win  = (W_Req && I_Req) ? !m_last : I_Req;
        ea   = win ? I_Addr : W_Addr;
        eds  = win ? I_DSize : W_DSize;
        ess  = win ? I_SSize : W_SSize;
        zero = (eds == 0) || (ess == 0);
        code = zero ? 2'b00 : (win ? 2'b01 : 2'b11);
        dn   = win ? 2'b01 : 2'b10;
        g    = (t + 1 > m_idle + 1) ? t + 1 : m_idle + 1;
        while (t < g - 1) begin
            tick();
            chk("pre_grant", {W_Grant, I_Grant}, 0);
        end
        tick();
        chk("w_grant", W_Grant, !win);
        chk("i_grant", I_Grant, win);
        chk("g_owner", Owner, win);
        chk("g_busy", Busy, 1);
        chk("g_start", DMAC_Start, code);
        chk("g_addr", DMAC_DRAM_START_A, ea);
        chk("g_dsize", DMAC_DRAM_SIZE, eds);
        chk("g_ssize", DMAC_SRAM_SIZE, ess);
        chk("g_dmac_rst", DMAC_RST, 0);
        m_last = win;
        if (zero) begin
            tick();
            chk("z_done", {W_Done, I_Done}, dn);
            chk("z_grant", {W_Grant, I_Grant}, 0);
            chk("z_start", DMAC_Start, 0);
            chk("z_dmac_rst", DMAC_RST, 0);
            chk("z_busy", Busy, 0);
            m_idle = t;
            return;
        end
        tout    = !(ddly > 0 && ddly <= TO);
        d       = tout ? g + TO : g + ddly;
        lo      = (sdly > 0 && g + sdly < d) ? g + sdly : d;
        idle_at = d + 2 + RC;
        DMA_Start = (sdly == 1);
        DMA_Done  = (ddly == 1);
        while (t < idle_at) begin
            tick();
            DMA_Start = (sdly > 0) && (t + 1 == g + sdly);
            DMA_Done  = (ddly > 0) && (t + 1 == g + ddly);
            chk("j_grant", {W_Grant, I_Grant}, 0);
            chk("j_start", DMAC_Start, (t < lo) ? code : 2'b00);
            chk("j_done", {W_Done, I_Done}, (t == d + 1) ? dn : 2'b00);
            chk("j_dmac_rst", DMAC_RST, (t >= d + 2) && (t < idle_at));
            chk("j_busy", Busy, t < idle_at);
            chk("j_err", Err, m_err || (tout && t >= d));
            if (t < idle_at) begin
                chk("j_owner", Owner, win);
                chk("j_addr", DMAC_DRAM_START_A, ea);
            end
        end
        DMA_Start = 1'b0;
        DMA_Done  = 1'b0;
        m_err  = m_err || tout;
        m_idle = idle_at;
    endtask

    task automatic rand_desc();
        W_Addr  = AW'($urandom);
        I_Addr  = AW'($urandom);
        W_DSize = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
        W_SSize = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
        I_DSize = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
        I_SSize = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
    endtask

    initial begin
        int g;
        int r;
        do_reset();

        // single weight job with a long transfer
        W_Addr = 22'h100000; W_DSize = 432; W_SSize = 432; W_Req = 1'b1;
        job(3, 1000);
        W_Req = 1'b0;

        // both requesting: weight first, then alternation
        do_reset();
        I_Addr = '0; I_DSize = 519168; I_SSize = 2704;
        W_Req = 1'b1; I_Req = 1'b1;
        job(2, 5);
        job(1, 7);
        job(4, 9);
        job(3, 3);   // DMA_Start and DMA_Done in the same ISSUE cycle
        W_Req = 1'b0; I_Req = 1'b0;

        // empty descriptors
        W_SSize = '0; W_Req = 1'b1;
        job(0, 0);
        W_Req = 1'b0;
        I_DSize = '0; I_Req = 1'b1;
        job(0, 0);
        I_Req = 1'b0;

        // randomized request patterns, descriptors and DMAC timing
        for (int n = 0; n < 30; n++) begin
            rand_desc();
            r = $urandom_range(0, 2);
            W_Req = (r != 1);
            I_Req = (r != 0);
            job($urandom_range(0, 6), $urandom_range(1, 30));
            W_Req = 1'b0; I_Req = 1'b0;
        end

        // watchdog: DMAC never finishes; Err then stays set through a good job
        W_Addr = 22'h0ABCDE; W_DSize = 64; W_SSize = 64; W_Req = 1'b1;
        job(2, 0);
        W_Req = 1'b0;
        I_DSize = 100; I_SSize = 100; I_Req = 1'b1;
        job(1, 4);
        I_Req = 1'b0;

        // reset in the middle of RUN
        I_Req = 1'b1;
        g = (t + 1 > m_idle + 1) ? t + 1 : m_idle + 1;
        while (t < g) tick();
        I_Req = 1'b0; DMA_Start = 1'b1;
        tick();
        DMA_Start = 1'b0;
        tick(); tick();
        chk("abort_busy", Busy, 1);
        RST = 1'b1;
        tick();
        chk_reset_vals();
        do_reset();

        // normal operation after the abort
        W_DSize = 16; W_SSize = 16; W_Req = 1'b1;
        job(1, 6);
        W_Req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_job_scheduler.md
# dma_job_scheduler

Sequences and shares the single DMAC between the weight loader and the image loader. Accepts one DRAM→SRAM transfer descriptor at a time from either requester through a round-robin arbiter and drives the DMAC's Start code, address and size inputs. It tracks the DMAC's DMA_Start/DMA_Done handshake and reports completion to the owning requester. Between jobs it pulses the DMAC reset and guards each job with a watchdog timeout.

## Interface
- ADDR_W, 22, DRAM start address width
- SIZE_W, 32, DRAM/SRAM transfer size width
- RST_CYCLES, 2, DMAC reset pulse length in cycles (≥1)
- TIMEOUT, 600000, max cycles from issue to DMA_Done; 0 disables watchdog

- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- W_Req  in  1  weight requester: descriptor valid, held until W_Grant
- W_Addr  in  ADDR_W  weight DRAM start address
- W_DSize / W_SSize  in  SIZE_W  weight DRAM read size / SRAM write size
- W_Grant  out  1  one-cycle pulse: descriptor captured
- W_Done  out  1  one-cycle pulse: weight job finished
- I_Req, I_Addr, I_DSize, I_SSize, I_Grant, I_Done: same set for the image requester
- DMAC_RST  out  1  reset to DMAC
- DMAC_Start  out  2  2'b11 weight job, 2'b01 image job, 2'b00 none
- DMAC_DRAM_START_A  out  ADDR_W  captured address
- DMAC_DRAM_SIZE / DMAC_SRAM_SIZE  out  SIZE_W  captured sizes
- DMA_Start  in  1  DMAC has accepted job
- DMA_Done  in  1  DMAC transfer complete
- Busy  out  1  state ≠ IDLE
- Owner  out  1  0 = weight, 1 = image (valid while Busy)
- Err  out  1  sticky: a job timed out; cleared only by RST

## Operation
- FSM states: DRST → IDLE → ISSUE → RUN → DONE → DRST.
- DRST: DMAC_RST=1 for exactly RST_CYCLES cycles (down-counter), then IDLE. Entered after RST and after every job.
- IDLE: if any Req, grant one requester, capture its Addr/DSize/SSize into output registers, set Owner, pulse its Grant, go to ISSUE.
  - Arbitration is round-robin. A last-owner pointer is reset to image, so weight wins the first tie. The pointer updates on every grant.
- Zero-size descriptor (DSize==0 or SSize==0): Grant, then Done on the next cycle. No DMAC activity and no DRST; return to IDLE.
- ISSUE: DMAC_Start = owner code, held until DMA_Start or DMA_Done is sampled high.
  - DMA_Start only: go to RUN.
  - DMA_Done, with or without DMA_Start: go to DONE.
- RUN: DMAC_Start=00; wait for DMA_Done, then go to DONE.
- DONE: pulse the owner's Done for 1 cycle, then go to DRST.
- Watchdog: a cycle counter clears on entering ISSUE and increments in ISSUE/RUN. When it reaches TIMEOUT (if nonzero): set Err, go to DONE (owner still receives Done).
- Req inputs are ignored outside IDLE. Descriptor inputs only matter in the grant cycle.
- DMA_Start/DMA_Done are ignored outside ISSUE/RUN.

## Timing
- All outputs are registered.
- Reset values: DMAC_RST=1; every other output is 0, including DMAC_Start=00, addresses/sizes, Busy, Owner and Err. State = DRST with the counter loaded.
- DMAC_RST stays high while RST is high and for RST_CYCLES cycles after RST falls.
- Req sampled high at edge k in IDLE:
  - Grant, Busy, DMAC_Start and captured fields are valid from edge k.
  - Grant is low again at edge k+1.
- DMA_Start sampled at edge m: DMAC_Start=00 from edge m.
- DMA_Done sampled at edge d:
  - Done is high for [d+1, d+2).
  - DMAC_RST is high from d+2 for RST_CYCLES cycles.
  - IDLE (Busy=0) is reached after that, so the earliest next Grant is d+3+RST_CYCLES.
- Timeout fires on the cycle the counter equals TIMEOUT. Err is set on the same edge that enters DONE.
- RST mid-job: immediate return to reset values. No Done is issued for the aborted job.

## Test plan
- Weight job (Addr=0x100000, DSize=SSize=432): DMAC_Start=11 with fields 0x100000/432/432; fake DMA_Start after 3 cycles, DMA_Done after 1000 → W_Done is a single pulse one cycle after Done, DMAC_RST is high for 2 cycles, then Busy=0.
- W_Req and I_Req both high from reset → weight granted first, image granted after the weight job's DRST (Start=01, Addr=0, DSize=519168, SSize=2704). Repeat both held high → grants alternate W, I, W, I.
- DMA_Start and DMA_Done high in the same cycle during ISSUE → straight to DONE, exactly one Done pulse, no RUN cycle.
- TIMEOUT=50, DMAC never asserts DMA_Done → Err=1 and owner Done pulse 50 cycles after issue. Err stays 1 through the next successful job until RST.
- Descriptor with SSize=0 → Grant, then Done on the next cycle. DMAC_Start stays 00 and DMAC_RST stays 0.
- RST asserted during RUN → all outputs return to reset values next edge, no Done pulse, and DMAC_RST is held for RST_CYCLES after RST falls.
